// File: rtl/pipe_buf_stage.sv
// -----------------------------------------------------------------------------
// pipe_buf_stage
//
// Elastic pipeline buffer placed between two pipeline stages. It carries one
// packed stage payload under a valid/ready handshake. A main (head) register
// and a skid register let the stage absorb one cycle of downstream
// back-pressure without a combinational path from out_ready to in_ready.
// A synchronous flush empties the stage and parks both registers at the
// bubble (NOP) payload. A saturating counter records back-pressured cycles.
//
// Parameters
//   WIDTH        payload width in bits (default 41: 9-bit PC + 32-bit instr)
//   BUBBLE_DATA  payload shown on out_data while the stage is empty
//   CNT_W        stall counter width
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous flush, highest priority
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      stage can accept a payload
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      stage holds a payload for downstream
//   out_ready  in   1      downstream accepts the payload
//   out_data   out  WIDTH  payload to downstream (BUBBLE_DATA when empty)
//   occupancy  out  2      number of held entries, 0..2
//   stall_cnt  out  CNT_W  saturating count of out_valid & !out_ready cycles
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | nothing held; out_data shows BUBBLE_DATA
//   ST_ONE   | head payload in main register, skid register unused
//   ST_FULL  | head in main, next payload in skid; upstream is stalled
// -----------------------------------------------------------------------------
module pipe_buf_stage #(
  parameter int unsigned             WIDTH       = 41,
  parameter logic [WIDTH-1:0]        BUBBLE_DATA = 41'h00000000013,
  parameter int unsigned             CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  main_q, main_d;
  logic [WIDTH-1:0]  skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occupancy_q;
  logic [CNT_W-1:0]  stall_q;

  logic              in_fire;
  logic              out_fire;

  // Handshakes use only registered flags, so in_ready never depends on
  // out_ready within the same cycle.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Anything offered this cycle is dropped; a concurrent pop is still
      // considered taken by downstream.
      state_d = ST_EMPTY;
      main_d  = BUBBLE_DATA;
      skid_d  = BUBBLE_DATA;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE_DATA;
          skid_d  = BUBBLE_DATA;
        end
      endcase
    end
  end

  // State, payload registers and the handshake/occupancy flags are all
  // updated together from the next state, so the flags are plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_DATA;
      skid_q      <= BUBBLE_DATA;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      unique case (state_d)
        ST_ONE:  occupancy_q <= 2'd1;
        ST_FULL: occupancy_q <= 2'd2;
        default: occupancy_q <= 2'd0;
      endcase
    end
  end

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_ONE;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // main_q may hold a stale payload after the last pop, hence the mux.
  assign out_data  = out_valid_q ? main_q : BUBBLE_DATA;
  assign occupancy = occupancy_q;
  assign stall_cnt = stall_q;

endmodule
